delay_line_sequencer: RTL and testbench

//  Control/address sequencer for the stereo delay-line RAM pair in the effects chain.

---
 rtl/delay_line_sequencer_pkg.sv | 30 +++
 rtl/delay_line_sequencer_if.sv | 31 +++
 rtl/delay_line_sequencer_sample_tick_gen.sv | 28 ++
 rtl/delay_line_sequencer.sv | 161 ++++++++++++++++
 tb/tb_delay_line_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_line_sequencer_pkg.sv
// Shared types and sizing helpers for the delay-line sequencer.
// Enum encodings match the numeric values the mixer and RAM mux decode.
package delay_pkg;

   typedef enum logic [1:0] {
      BYPASS = 2'd0,
      DELAY  = 2'd1,
      ECHO   = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      DRY      = 2'd0,
      FEEDBACK = 2'd1,
      ZERO     = 2'd2
   } din_sel_t;

   typedef enum logic [1:0] {
      S_BYPASS,
      S_RUN,
      S_FADE,
      S_FLUSH
   } state_t;

   localparam int DEPTH_DEFAULT = 30000;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/delay_line_sequencer_if.sv
// Control/address bundle between the delay-line sequencer and the RAM/mixer side.
// master = sequencer, slave = whoever sets the enables and consumes the addresses.
interface delay_line_sequencer_if #(
   parameter int ADDR_W = 15,
   parameter int GAIN_W = 8
);
   import delay_pkg::*;

   logic              delay_enable;
   logic              echo_enable;
   logic [ADDR_W-1:0] delay_len;
   logic              sample_tick;
   logic [ADDR_W-1:0] addr_wr;
   logic [ADDR_W-1:0] addr_rd;
   logic              ram_we;
   din_sel_t          din_sel;
   logic [GAIN_W-1:0] wet_gain;
   mode_t             mode;
   logic              busy;

   modport master (
      input  delay_enable, echo_enable, delay_len,
      output sample_tick, addr_wr, addr_rd, ram_we, din_sel, wet_gain, mode, busy
   );

   modport slave (
      output delay_enable, echo_enable, delay_len,
      input  sample_tick, addr_wr, addr_rd, ram_we, din_sel, wet_gain, mode, busy
   );

endinterface

// File: rtl/delay_line_sequencer_sample_tick_gen.sv
// Free-running sample-rate divider: one-cycle sample_tick every CLK_DIV clocks.
// tick_pre is the combinational look-ahead so other logic can register with the tick.
module sample_tick_gen #(
   parameter int CLK_DIV = 256
) (
   input  logic clk_in,
   input  logic rst_in,
   output logic tick_pre,
   output logic sample_tick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] cnt_q;

   assign tick_pre = (cnt_q == '0);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         cnt_q       <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= tick_pre;
         cnt_q       <= tick_pre ? CNT_W'(CLK_DIV - 1) : cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: rtl/delay_line_sequencer.sv
// Address/control sequencer for the stereo delay-line RAM pair: write/read pointers,
// RAM write-data select and the wet-gain ramp, with a flush so stale audio never replays.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_FLUSH  | zero every RAM location, one per clock; busy high
//   S_BYPASS | idle, RAM known clean, wet path muted
//   S_RUN    | write one sample per tick, wet gain ramps up
//   S_FADE   | keep writing, wet gain ramps down; flush once silent
module delay_line_sequencer
   import delay_pkg::*;
#(
   parameter int DEPTH     = DEPTH_DEFAULT,
   parameter int CLK_DIV   = 256,
   parameter int GAIN_W    = 8,
   parameter int RAMP_STEP = 16
) (
   input logic                   clk_in,
   input logic                   rst_in,
   delay_line_sequencer_if.master bus
);

   localparam int                ADDR_W    = addr_w(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
   localparam logic [GAIN_W-1:0] STEP_G    = GAIN_W'(RAMP_STEP);

   state_t            state_q;
   mode_t             act_mode_q;
   mode_t             mode_q;
   mode_t             req;
   din_sel_t          din_sel_q;
   logic [ADDR_W-1:0] flush_cnt_q;
   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] wr_ptr_nxt;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] len_clamped;
   logic [ADDR_W-1:0] addr_wr_q;
   logic [ADDR_W-1:0] addr_rd_q;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   rd_diff;
   logic [GAIN_W-1:0] gain_q;
   logic [GAIN_W-1:0] gain_up;
   logic [GAIN_W-1:0] gain_dn;
   logic [GAIN_W:0]   gain_sum;
   logic              ram_we_q;
   logic              busy_q;
   logic              tick_pre;
   logic              sample_tick;

   sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .tick_pre    (tick_pre),
      .sample_tick (sample_tick)
   );

   always_comb begin
      req = BYPASS;
      if (bus.delay_enable)     req = DELAY;
      else if (bus.echo_enable) req = ECHO;
   end

   always_comb begin
      len_clamped = bus.delay_len;
      if (bus.delay_len == '0)            len_clamped = ADDR_W'(1);
      else if (bus.delay_len > LAST_ADDR) len_clamped = LAST_ADDR;
   end

   // A borrow sets the top bit of the widened difference; adding DEPTH folds it back.
   assign rd_diff    = {1'b0, wr_ptr_q} - {1'b0, len_q};
   assign rd_addr    = rd_diff[ADDR_W] ? ADDR_W'(rd_diff + DEPTH_EXT) : rd_diff[ADDR_W-1:0];
   assign wr_ptr_nxt = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDR_W'(1);

   assign gain_sum = {1'b0, gain_q} + {1'b0, STEP_G};
   assign gain_up  = gain_sum[GAIN_W] ? {GAIN_W{1'b1}} : gain_sum[GAIN_W-1:0];
   assign gain_dn  = (gain_q < STEP_G) ? '0 : gain_q - STEP_G;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= S_FLUSH;
         act_mode_q  <= BYPASS;
         mode_q      <= BYPASS;
         din_sel_q   <= DRY;
         flush_cnt_q <= '0;
         wr_ptr_q    <= '0;
         len_q       <= ADDR_W'(1);
         addr_wr_q   <= '0;
         addr_rd_q   <= '0;
         gain_q      <= '0;
         ram_we_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         ram_we_q <= 1'b0;
         busy_q   <= 1'b0;
         case (state_q)
            S_FLUSH: begin
               ram_we_q  <= 1'b1;
               busy_q    <= 1'b1;
               din_sel_q <= ZERO;
               addr_wr_q <= flush_cnt_q;
               mode_q    <= BYPASS;
               gain_q    <= '0;
               if (flush_cnt_q == LAST_ADDR) begin
                  flush_cnt_q <= '0;
                  wr_ptr_q    <= '0;
                  if (req != BYPASS) begin
                     state_q    <= S_RUN;
                     act_mode_q <= req;
                     len_q      <= len_clamped;
                  end else begin
                     state_q <= S_BYPASS;
                  end
               end else begin
                  flush_cnt_q <= flush_cnt_q + ADDR_W'(1);
               end
            end
            S_BYPASS: begin
               mode_q    <= BYPASS;
               din_sel_q <= DRY;
               gain_q    <= '0;
               if (req != BYPASS) begin
                  state_q    <= S_RUN;
                  act_mode_q <= req;
                  len_q      <= len_clamped;
               end
            end
            S_RUN, S_FADE: begin
               mode_q <= act_mode_q;
               if (tick_pre) begin
                  ram_we_q  <= 1'b1;
                  addr_wr_q <= wr_ptr_q;
                  addr_rd_q <= rd_addr;
                  din_sel_q <= (act_mode_q == ECHO) ? FEEDBACK : DRY;
                  wr_ptr_q  <= wr_ptr_nxt;
                  gain_q    <= (state_q == S_RUN) ? gain_up : gain_dn;
               end
               // Returning to the running mode wins over a simultaneous silent-gain flush.
               if (state_q == S_RUN) begin
                  if (req != act_mode_q) state_q <= S_FADE;
               end else if (req == act_mode_q) begin
                  state_q <= S_RUN;
               end else if (gain_q == '0) begin
                  state_q <= S_FLUSH;
               end
            end
            default: state_q <= S_FLUSH;
         endcase
      end
   end

   assign bus.sample_tick = sample_tick;
   assign bus.addr_wr     = addr_wr_q;
   assign bus.addr_rd     = addr_rd_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.din_sel     = din_sel_q;
   assign bus.wet_gain    = gain_q;
   assign bus.mode        = mode_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Directed bench for delay_line_sequencer: per-cycle behavioural model plus literal checkpoints.
module tb_delay_line_sequencer;
   import delay_pkg::*;

   localparam int DEPTH     = 16;
   localparam int CLK_DIV   = 4;
   localparam int GAIN_W    = 8;
   localparam int RAMP_STEP = 64;
   localparam int ADDR_W    = 4;
   localparam int GMAX      = 255;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   busy_seen = 0;

   delay_line_sequencer_if #(.ADDR_W(ADDR_W), .GAIN_W(GAIN_W)) bus ();

   delay_line_sequencer #(
      .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .GAIN_W(GAIN_W), .RAMP_STEP(RAMP_STEP)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_len(input int l);
      if (l < 1) return 1;
      if (l > DEPTH - 1) return DEPTH - 1;
      return l;
   endfunction

   // Behavioural model: what each output must be after every clock edge.
   typedef enum {P_WIPE, P_IDLE, P_PLAY, P_FADEOUT} phase_e;
   phase_e m_phase;
   bit     m_live = 0;
   bit     m_tick;
   int     m_cyc, m_fcnt, m_wp, m_len, m_gain, m_act, m_req, m_old_gain;
   int     e_tick, e_we, e_awr, e_ard, e_din, e_gain, e_mode, e_busy;

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_live = 1; m_phase = P_WIPE;
         m_cyc = 0; m_fcnt = 0; m_wp = 0; m_len = 1; m_gain = 0; m_act = 0;
         e_tick = 0; e_we = 0; e_awr = 0; e_ard = 0; e_din = 0; e_gain = 0; e_mode = 0; e_busy = 0;
      end else begin
         m_tick = ((m_cyc % CLK_DIV) == 0);
         m_cyc++;
         m_req = bus.delay_enable ? 1 : (bus.echo_enable ? 2 : 0);
         m_old_gain = m_gain;
         e_tick = m_tick; e_we = 0; e_busy = 0;
         case (m_phase)
            P_WIPE: begin
               e_we = 1; e_busy = 1; e_awr = m_fcnt; e_din = 2; e_mode = 0;
               if (m_fcnt == DEPTH - 1) begin
                  m_fcnt = 0; m_wp = 0;
                  if (m_req != 0) begin
                     m_act = m_req; m_len = clamp_len(int'(bus.delay_len)); m_phase = P_PLAY;
                  end else m_phase = P_IDLE;
               end else m_fcnt++;
            end
            P_IDLE: begin
               e_mode = 0;
               if (m_req != 0) begin
                  m_act = m_req; m_len = clamp_len(int'(bus.delay_len)); m_phase = P_PLAY;
               end
            end
            default: begin
               e_mode = m_act;
               if (m_tick) begin
                  e_we = 1; e_awr = m_wp; e_ard = (m_wp - m_len + DEPTH) % DEPTH;
                  e_din = (m_act == 2) ? 1 : 0;
                  m_wp = (m_wp + 1) % DEPTH;
                  if (m_phase == P_PLAY) m_gain = (m_old_gain + RAMP_STEP > GMAX) ? GMAX : m_old_gain + RAMP_STEP;
                  else m_gain = (m_old_gain < RAMP_STEP) ? 0 : m_old_gain - RAMP_STEP;
               end
               if (m_phase == P_PLAY) begin
                  if (m_req != m_act) m_phase = P_FADEOUT;
               end else if (m_req == m_act) m_phase = P_PLAY;
               else if (m_old_gain == 0) m_phase = P_WIPE;
            end
         endcase
         e_gain = m_gain;
      end
   end

   always @(negedge clk_in) begin
      if (m_live) begin
         chk("sample_tick", bus.sample_tick, e_tick);
         chk("ram_we", bus.ram_we, e_we);
         chk("busy", bus.busy, e_busy);
         chk("mode", int'(bus.mode), e_mode);
         chk("wet_gain", bus.wet_gain, e_gain);
         if (e_we != 0) begin
            chk("addr_wr", bus.addr_wr, e_awr);
            chk("din_sel", int'(bus.din_sel), e_din);
            if (e_busy == 0) chk("addr_rd", bus.addr_rd, e_ard);
         end
      end
   end

   task automatic wait_tick(input bit now_ok);
      int n = 0;
      if (now_ok && bus.sample_tick) return;
      do begin
         @(negedge clk_in);
         n++;
         busy_seen += int'(bus.busy);
      end while (!bus.sample_tick && n < 3 * CLK_DIV);
      if (!bus.sample_tick) begin
         n_tests++; n_fail++;
         $display("FAIL tick_timeout: no sample_tick within %0d cycles", 3 * CLK_DIV);
      end
   endtask

   task automatic wait_busy(input bit level);
      int n = 0;
      while (bus.busy != level && n < 64) begin
         @(negedge clk_in);
         n++;
      end
      if (bus.busy != level) begin
         n_tests++; n_fail++;
         $display("FAIL busy_timeout: busy never reached %0d", level);
      end
   endtask

   task automatic wait_active();
      int n = 0;
      do begin
         @(negedge clk_in);
         n++;
      end while (bus.mode == BYPASS && n < 16);
      chk("mode_became_active", int'(bus.mode != BYPASS), 1);
   endtask

   int gains[5];
   int exp_up[5]   = '{64, 128, 192, 255, 255};
   int exp_down[4] = '{191, 127, 63, 0};
   int cnt;
   bit hit;

   initial begin
      bus.delay_enable = 1'b0;
      bus.echo_enable  = 1'b0;
      bus.delay_len    = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_tick", bus.sample_tick, 0);
      chk("rst_addr_wr", bus.addr_wr, 0);

      // 1: power-up flush, then idle bypass
      rst_in = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk_in);
         chk("t1_flush_we", bus.ram_we, 1);
         chk("t1_flush_addr", bus.addr_wr, i);
         chk("t1_flush_din", int'(bus.din_sel), 2);
         chk("t1_flush_busy", bus.busy, 1);
      end
      @(negedge clk_in);
      chk("t1_busy_done", bus.busy, 0);
      chk("t1_mode_bypass", int'(bus.mode), 0);
      chk("t1_we_off", bus.ram_we, 0);
      cnt = 0;
      repeat (2 * CLK_DIV) begin
         @(negedge clk_in);
         cnt += int'(bus.ram_we);
      end
      chk("t1_idle_no_we", cnt, 0);

      // 2: bypass -> delay, gain ramps and saturates
      bus.delay_len = 4'd4;
      bus.delay_enable = 1'b1;
      wait_active();
      hit = 0;
      for (int k = 0; k < 5; k++) begin
         wait_tick(k == 0);
         gains[k] = int'(bus.wet_gain);
         if (k == 0) begin
            chk("t2_mode", int'(bus.mode), 1);
            chk("t2_din_dry", int'(bus.din_sel), 0);
         end
         if (bus.addr_wr == 4'd2) begin
            chk("t2_addr_rd_at_wr2", bus.addr_rd, 14);
            hit = 1;
         end
      end
      for (int k = 0; k < 5; k++) chk("t2_gain_ramp", gains[k], exp_up[k]);
      chk("t2_saw_addr_wr2", int'(hit), 1);

      // 3: delay -> echo through fade and flush
      bus.delay_enable = 1'b0;
      bus.echo_enable  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_tick(0);
         chk("t3_fade_gain", bus.wet_gain, exp_down[k]);
      end
      wait_busy(1'b1);
      cnt = 1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_in);
         if (!bus.busy) break;
         cnt++;
      end
      chk("t3_flush_len", cnt, 16);
      chk("t3_mode_echo", int'(bus.mode), 2);
      wait_tick(1);
      chk("t3_din_feedback", int'(bus.din_sel), 1);
      chk("t3_gain_from_zero", bus.wet_gain, 64);

      // 4: back to bypass, then both enables with delay_len clamped to 1
      bus.echo_enable = 1'b0;
      wait_busy(1'b1);
      wait_busy(1'b0);
      chk("t4_bypass", int'(bus.mode), 0);
      bus.delay_len    = '0;
      bus.delay_enable = 1'b1;
      bus.echo_enable  = 1'b1;
      wait_active();
      wait_tick(1);
      chk("t4_delay_wins", int'(bus.mode), 1);
      chk("t4_addr_wr0", bus.addr_wr, 0);
      chk("t4_addr_rd_len1", bus.addr_rd, 15);
      bus.delay_len = 4'd8;
      wait_tick(0);
      chk("t4_addr_wr1", bus.addr_wr, 1);
      chk("t4_len_held", bus.addr_rd, 0);

      // 5: asynchronous reset pulse between clock edges
      wait_tick(0);
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("t5_rst_we", bus.ram_we, 0);
      chk("t5_rst_gain", bus.wet_gain, 0);
      chk("t5_rst_mode", int'(bus.mode), 0);
      chk("t5_rst_addr_wr", bus.addr_wr, 0);
      chk("t5_rst_addr_rd", bus.addr_rd, 0);
      chk("t5_rst_din", int'(bus.din_sel), 0);
      chk("t5_rst_busy", bus.busy, 0);
      chk("t5_rst_tick", bus.sample_tick, 0);
      #1 rst_in = 1'b0;
      @(negedge clk_in);
      chk("t5_flush_busy", bus.busy, 1);
      chk("t5_flush_addr0", bus.addr_wr, 0);
      chk("t5_flush_we", bus.ram_we, 1);
      wait_busy(1'b0);
      chk("t5_run_delay", int'(bus.mode), 1);

      // 6: fade interrupted at gain 128 returns to run without a flush
      wait_tick(1);
      chk("t6_gain64", bus.wet_gain, 64);
      wait_tick(0);
      chk("t6_gain128", bus.wet_gain, 128);
      wait_tick(0);
      chk("t6_gain192", bus.wet_gain, 192);
      bus.delay_enable = 1'b0;
      busy_seen = 0;
      wait_tick(0);
      chk("t6_fade128", bus.wet_gain, 128);
      bus.delay_enable = 1'b1;
      wait_tick(0);
      chk("t6_rerun192", bus.wet_gain, 192);
      wait_tick(0);
      chk("t6_rerun255", bus.wet_gain, 255);
      chk("t6_no_flush", busy_seen, 0);
      chk("t6_mode", int'(bus.mode), 1);

      repeat (2) @(negedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
